// File: rtl/token_window_counter.sv
// Counts '1' tokens over windows of WINDOW qualified samples. Each window
// total is handed out through a single-entry valid/ready register; totals that
// arrive while the register is still unread are dropped and counted.
module token_window_counter #(
  parameter int WINDOW = 16,
  parameter int CNT_W  = $clog2(WINDOW + 1),
  parameter int DROP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic              a,
  output logic [CNT_W-1:0]  count_o,
  output logic              count_valid,
  input  logic              count_ready,
  output logic              drop_pulse,
  output logic [DROP_W-1:0] drop_cnt
);
  localparam int IDX_W = (WINDOW > 2) ? $clog2(WINDOW) : 1;

  typedef enum logic {EMPTY, FULL} state_t;

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic [CNT_W-1:0]  acc;
  logic              done;
  logic              take;
  logic [CNT_W-1:0]  total;

  // clr wins over a coincident last sample, so that window never completes
  assign done        = !clr && en && (idx == IDX_W'(WINDOW - 1));
  assign total       = acc + CNT_W'(a);
  assign count_valid = (state == FULL);
  assign take        = count_valid && count_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= '0;
      acc <= '0;
    end else if (clr || done) begin
      idx <= '0;
      acc <= '0;
    end else if (en) begin
      idx <= idx + IDX_W'(1);
      acc <= total;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= EMPTY;
      count_o    <= '0;
      drop_pulse <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      drop_pulse <= 1'b0;
      case (state)
        EMPTY: begin
          if (done) begin
            count_o <= total;
            state   <= FULL;
          end
        end
        FULL: begin
          if (take) begin
            if (done) count_o <= total;
            else      state   <= EMPTY;
          end else if (done) begin
            // held total stays put; the new one is lost
            drop_pulse <= 1'b1;
            if (drop_cnt != '1) drop_cnt <= drop_cnt + DROP_W'(1);
          end
        end
      endcase
    end
  end
endmodule
